// File: rtl/display_pkg.sv
// Shared types and board constants for the display path.
// The debounce state encoding and the clock rate from which the debounce time is derived.
package display_pkg;

    typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} dbnc_state_t;

    localparam int CLK_FREQ_HZ = 27000000;
    localparam int DEBOUNCE_MS = 10;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous board pins.
// It has a synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_d, s1_q;
    logic s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/btn_debounce_sel.sv
// Push-button conditioner: synchronise, debounce, edge pulses and display select.
// Define BTN_TOGGLE_EN to make btn_sel toggle on each press instead of following the level.
module btn_debounce_sel
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_sel
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic        pin_p;
    logic        s2;
    dbnc_state_t state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic        level_d, level_q;
    logic        rise_d, rise_q;
    logic        fall_d, fall_q;

    assign pin_p = btn_in ^ BTN_ACTIVE_LOW;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_p),
        .q   (s2)
    );

    // A new level must be seen DEBOUNCE_CYCLES+1 times in a row; any bounce returns to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (s2) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_d = IDLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!s2) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_d = IDLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef BTN_TOGGLE_EN
    logic sel_d, sel_q;

    // Each accepted press flips between the corrected-word and syndrome displays.
    always_comb begin
        sel_d = sel_q;
        if (rise_d) begin
            sel_d = ~sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign btn_sel = sel_q;
`else
    assign btn_sel = level_q;
`endif

endmodule

// File: tb/tb_btn_debounce_sel.sv
// Self-checking bench for btn_debounce_sel with DEBOUNCE_CYCLES = 4.
// It compares an active-high and an active-low instance against a run-length reference model.
module tb_btn_debounce_sel;

    localparam int N = 4;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_in_n;
    logic level_a, rise_a, fall_a, sel_a;
    logic level_b, rise_b, fall_b, sel_b;

    int checks;
    int errors;

    // The model sees the pin two edges late.
    logic pipe[$];
    logic m_level, m_rise, m_fall, m_sel;
    int   run_len;

    btn_debounce_sel #(.DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(1'b0)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (level_a),
        .btn_rise  (rise_a),
        .btn_fall  (fall_a),
        .btn_sel   (sel_a)
    );

    btn_debounce_sel #(.DEBOUNCE_CYCLES(N), .BTN_ACTIVE_LOW(1'b1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in_n),
        .btn_level (level_b),
        .btn_rise  (rise_b),
        .btn_fall  (fall_b),
        .btn_sel   (sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A level change is accepted once the delayed pin has differed from it N+1 times in a row.
    task automatic model_edge(input logic pin, input logic r);
        logic obs;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            pipe    = '{1'b0, 1'b0};
            m_level = 1'b0;
            m_sel   = 1'b0;
            run_len = 0;
        end else begin
            obs = pipe.pop_front();
            pipe.push_back(pin);
            if (obs != m_level) run_len++;
            else run_len = 0;
            if (run_len == N + 1) begin
                run_len = 0;
                m_level = obs;
                if (obs) begin
                    m_rise = 1'b1;
`ifdef BTN_TOGGLE_EN
                    m_sel = ~m_sel;
`endif
                end else begin
                    m_fall = 1'b1;
                end
            end
`ifndef BTN_TOGGLE_EN
            m_sel = m_level;
`endif
        end
    endtask

    task automatic check_output();
        check_bit("level_a", level_a, m_level);
        check_bit("rise_a", rise_a, m_rise);
        check_bit("fall_a", fall_a, m_fall);
        check_bit("sel_a", sel_a, m_sel);
        check_bit("level_b", level_b, m_level);
        check_bit("rise_b", rise_b, m_rise);
        check_bit("fall_b", fall_b, m_fall);
        check_bit("sel_b", sel_b, m_sel);
        check_bit("rise_fall_excl", rise_a & fall_a, 1'b0);
    endtask

    task automatic apply_stimulus(input logic pin, input logic r);
        btn_in   = pin;
        btn_in_n = ~pin;
        rst      = r;
        @(posedge clk);
        model_edge(pin, r);
        #1;
        check_output();
    endtask

    initial begin
        int found;
        logic pin;
        int hold;
        checks   = 0;
        errors   = 0;
        m_level  = 1'b0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        m_sel    = 1'b0;
        run_len  = 0;
        pipe     = '{1'b0, 1'b0};
        rst      = 1'b1;
        btn_in   = 1'b0;
        btn_in_n = 1'b1;

        repeat (3) apply_stimulus(1'b0, 1'b1);
        repeat (20) apply_stimulus(1'b0, 1'b0);

        found = -1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 1'b0);
            if (rise_a === 1'b1 && found < 0) found = i;
        end
        checks++;
        assert (found == N + 2) else begin
            errors++;
            $error("[TB] FAIL press_latency observed=%0d expected=%0d", found, N + 2);
        end

        found = -1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b0, 1'b0);
            if (fall_a === 1'b1 && found < 0) found = i;
        end
        checks++;
        assert (found == N + 2) else begin
            errors++;
            $error("[TB] FAIL release_latency observed=%0d expected=%0d", found, N + 2);
        end

        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        repeat (12) apply_stimulus(1'b0, 1'b0);

        repeat (4) apply_stimulus(1'b1, 1'b0);
        repeat (2) apply_stimulus(1'b1, 1'b1);
        found = -1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b1, 1'b0);
            if (rise_a === 1'b1 && found < 0) found = i;
        end
        checks++;
        assert (found == N + 2) else begin
            errors++;
            $error("[TB] FAIL post_reset_latency observed=%0d expected=%0d", found, N + 2);
        end
        repeat (10) apply_stimulus(1'b0, 1'b0);

        repeat (3) begin
            repeat (9) apply_stimulus(1'b1, 1'b0);
            repeat (9) apply_stimulus(1'b0, 1'b0);
        end

        pin = 1'b0;
        repeat (120) begin
            pin  = ~pin;
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) begin
                apply_stimulus(pin, ($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0);
            end
        end
        repeat (10) apply_stimulus(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
